mem_dbus_stage: RTL
===================

Name: mem_dbus_stage

Overview:
- MEM pipeline stage between the ex_mem register and the mem_wb register.
- Executes load/store instructions over a request/acknowledge data-bus handshake. The bus may take any number of cycles to answer.
- Raises a stall request while an access is outstanding. Aligns and extends load data.
- Passes non-memory results, HI/LO and whilo straight through to mem_wb.

Parameters:
- none; opcode and bus widths come from defines.v

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wd_i  in  5  destination register address from ex_mem
- wreg_i  in  1  register write enable from ex_mem
- wdata_i  in  32  ALU result from ex_mem
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- whilo_i  in  1  HI/LO write enable
- aluop_i  in  8  operation code (EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP)
- mem_addr_i  in  32  effective byte address
- reg2_i  in  32  store data
- stall  in  6  pipeline stall vector; stall[4] refers to this stage
- wd_o  out  5  to mem_wb mem_wd
- wreg_o  out  1  to mem_wb mem_wreg
- wdata_o  out  32  to mem_wb mem_wdata
- hi_o  out  32  to mem_wb mem_hi
- lo_o  out  32  to mem_wb mem_lo
- whilo_o  out  1  to mem_wb mem_whilo
- stallreq_o  out  1  stall request to the controller
- dbus_req_o  out  1  bus request (registered)
- dbus_we_o  out  1  1 = write (registered)
- dbus_addr_o  out  32  word address; bits [1:0] are always 00 (registered)
- dbus_sel_o  out  4  byte lanes (registered)
- dbus_wdata_o  out  32  write data (registered)
- dbus_ack_i  in  1  access complete; read data is valid in the same cycle
- dbus_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - dbus_* outputs = 0.
  - Latched data register = 0.
  - Combinational outputs forced to NOPRegAddr / WriteDisable / ZeroWord; stallreq_o=0.
  - Reset in BUSY drops dbus_req_o immediately; the pending access is abandoned.
- Byte order is big-endian. Address offset 0 selects bits [31:24], giving sel 1000. Offset 3 gives sel 0001.
- Halfword: offset 0 gives sel 1100, offset 2 gives sel 0011. Word gives sel 1111.
- Store data is replicated into every lane: byte replicated 4x, halfword replicated 2x.
- Loads:
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
  - LW takes the whole word.
  - Stores force wreg_o=0.
- Misaligned access (halfword with addr[0]=1, word with addr[1:0]≠00):
  - No bus cycle is issued.
  - wreg_o=0 and stallreq_o=0.
  - The instruction retires as a NOP write.
- Non-memory aluop: every output equals its corresponding input in the same cycle; stallreq_o=0; FSM stays IDLE.
- HI/LO and whilo always pass through unchanged.
- FSM:
  - IDLE:
    - Valid aligned memory op present: stallreq_o=1.
    - At the next edge: go BUSY and register req=1 plus we/addr/sel/wdata.
  - BUSY:
    - dbus_req_o=1, stallreq_o=1.
    - On dbus_ack_i=1: latch the aligned/extended load result, drop req at the edge, go DONE.
    - With no ack, remain in BUSY indefinitely; the request fields stay stable.
  - DONE:
    - stallreq_o=0; wdata_o = latched result (for loads).
    - At an edge with stall[4]=NoStop (instruction moves to mem_wb): go IDLE.
    - stall[4]=Stop (stalled by a later source): stay DONE and keep the output.
- dbus_ack_i outside BUSY is ignored.
- Minimum latency: a memory op holds MEM for 3 cycles (IDLE, BUSY with immediate ack, DONE), i.e. 2 stall cycles.
- Back-to-back memory ops: the next op is presented only after DONE→IDLE, so a second access starts at the earliest 1 cycle after the first retires.
- Pass-through outputs stay combinational. Only the bus interface, the FSM and the latched data register are sequential.

Decomposition:
- defines.v holds:
  - EXE_*_OP codes, RegBus, RegAddrBus, Stop/NoStop, ZeroWord, NOPRegAddr.
  - New constants: DBusSelBus (3:0) and state encodings MemIdle/MemBusy/MemDone.
- Natural sub-module: mem_align, purely combinational. It produces sel/replicated wdata from aluop and addr, and extracts and extends load data. It is shared with a future instruction-side or uncached path.

Test Plan:
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - Expected stallreq_o high for 4 cycles.
  - Expected dbus_addr_o=0x100 and sel=1111.
  - Expected wdata_o=0xDEADBEEF and wreg_o=1 in DONE.
- LB at addr 0x103, rdata 0x123456F0 → wdata_o=0xFFFFFFF0; the same access with LBU → 0x000000F0.
- SH reg2=0x0000ABCD at addr 0x202 → sel=0011, dbus_wdata_o=0xABCDABCD, we=1, wreg_o=0.
- LW at addr 0x101 → no dbus_req_o, stallreq_o=0, wreg_o=0.
- Load completes while stall[4] is held by a later source for 2 cycles → state stays DONE, wdata_o stays stable, and the FSM goes IDLE only at the first NoStop edge.
- rst pulsed mid-BUSY → dbus_req_o falls asynchronously; after release an ADD passes through unchanged with stallreq_o=0.

Source files
------------

// File: rtl/mem_dbus_stage_pkg.sv
// Shared constants and types for the MEM data-bus stage.
package mem_dbus_stage_pkg;

    // Bus widths
    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;
    localparam int DBusSelW    = 4;

    // Common values
    localparam logic [RegBusW-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBusW-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                   WriteEnable  = 1'b1;
    localparam logic                   WriteDisable = 1'b0;
    localparam logic                   Stop         = 1'b1;
    localparam logic                   NoStop       = 1'b0;

    // Load/store operation codes
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    // MEM access FSM states
    typedef enum logic [1:0] {
        MemIdle = 2'b00,
        MemBusy = 2'b01,
        MemDone = 2'b10
    } mem_state_e;

    typedef logic [DBusSelW-1:0] dbus_sel_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte selects and store-data replication for a
// bus access, plus big-endian extraction and extension of load data.
module mem_align
    import mem_dbus_stage_pkg::*;
(
    input  logic [7:0]         i_aluop,
    input  logic [1:0]         i_offset,
    input  logic [RegBusW-1:0] i_reg2,
    input  logic [RegBusW-1:0] i_rdata,
    output logic               o_is_mem,
    output logic               o_is_load,
    output logic               o_is_store,
    output logic               o_aligned,
    output dbus_sel_t          o_sel,
    output logic [RegBusW-1:0] o_wdata,
    output logic [RegBusW-1:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword; offset 0 is the most significant lane.
    always_comb begin
        w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
        case (i_offset)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Decode the operation into lane selects, store data and load result.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        o_is_mem   = 1'b0;
        o_is_load  = 1'b0;
        o_is_store = 1'b0;
        o_aligned  = 1'b1;
        o_sel      = 4'b0000;
        o_wdata    = ZeroWord;
        o_ldata    = ZeroWord;
        case (i_aluop)
            EXE_LB_OP, EXE_LBU_OP: begin
                o_is_mem  = 1'b1;
                o_is_load = 1'b1;
                o_sel     = 4'b1000 >> i_offset;
                o_ldata   = (i_aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte}
                                                   : {24'h0, w_byte};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                o_is_mem  = 1'b1;
                o_is_load = 1'b1;
                o_aligned = ~i_offset[0];
                o_sel     = i_offset[1] ? 4'b0011 : 4'b1100;
                o_ldata   = (i_aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half}
                                                   : {16'h0, w_half};
            end
            EXE_LW_OP: begin
                o_is_mem  = 1'b1;
                o_is_load = 1'b1;
                o_aligned = (i_offset == 2'b00);
                o_sel     = 4'b1111;
                o_ldata   = i_rdata;
            end
            EXE_SB_OP: begin
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
                o_sel      = 4'b1000 >> i_offset;
                o_wdata    = {4{i_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
                o_aligned  = ~i_offset[0];
                o_sel      = i_offset[1] ? 4'b0011 : 4'b1100;
                o_wdata    = {2{i_reg2[15:0]}};
            end
            EXE_SW_OP: begin
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
                o_aligned  = (i_offset == 2'b00);
                o_sel      = 4'b1111;
                o_wdata    = i_reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dbus_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus, stalls the
// pipe while an access is outstanding, and passes everything else through.
module mem_dbus_stage
    import mem_dbus_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegAddrBusW-1:0] wd_i,
    input  logic                   wreg_i,
    input  logic [RegBusW-1:0]     wdata_i,
    input  logic [RegBusW-1:0]     hi_i,
    input  logic [RegBusW-1:0]     lo_i,
    input  logic                   whilo_i,
    input  logic [7:0]             aluop_i,
    input  logic [RegBusW-1:0]     mem_addr_i,
    input  logic [RegBusW-1:0]     reg2_i,
    input  logic [5:0]             stall,
    output logic [RegAddrBusW-1:0] wd_o,
    output logic                   wreg_o,
    output logic [RegBusW-1:0]     wdata_o,
    output logic [RegBusW-1:0]     hi_o,
    output logic [RegBusW-1:0]     lo_o,
    output logic                   whilo_o,
    output logic                   stallreq_o,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [RegBusW-1:0]     dbus_addr_o,
    output dbus_sel_t              dbus_sel_o,
    output logic [RegBusW-1:0]     dbus_wdata_o,
    input  logic                   dbus_ack_i,
    input  logic [RegBusW-1:0]     dbus_rdata_i
);

    mem_state_e         r_state;
    mem_state_e         w_next;
    logic [RegBusW-1:0] r_ldata;

    logic               w_is_mem;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_aligned;
    dbus_sel_t          w_sel;
    logic [RegBusW-1:0] w_wdata;
    logic [RegBusW-1:0] w_ldata;
    logic               w_start;
    logic               w_unused;

    // Only this stage's stall bit matters here.
    assign w_unused = ^{stall[5], stall[3:0]};

    mem_align u_align (
        .i_aluop    (aluop_i),
        .i_offset   (mem_addr_i[1:0]),
        .i_reg2     (reg2_i),
        .i_rdata    (dbus_rdata_i),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_aligned  (w_aligned),
        .o_sel      (w_sel),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    // Misaligned ops never reach the bus; they retire as NOP writes.
    assign w_start = (r_state == MemIdle) && w_is_mem && w_aligned;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= MemIdle;
        else     r_state <= w_next;
    end

    // Next-state logic: IDLE -> BUSY on a valid op, BUSY -> DONE on ack,
    // DONE -> IDLE once the instruction moves on to mem_wb.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MemIdle: if (w_start) w_next = MemBusy;
            MemBusy: if (dbus_ack_i) w_next = MemDone;
            MemDone: if (stall[4] == NoStop) w_next = MemIdle;
            default: w_next = MemIdle;
        endcase
    end

    // Bus request fields and load-result capture; fields hold while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= ZeroWord;
            dbus_sel_o   <= 4'b0000;
            dbus_wdata_o <= ZeroWord;
            r_ldata      <= ZeroWord;
        end else begin
            case (r_state)
                MemIdle: begin
                    if (w_start) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= w_is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel_o   <= w_sel;
                        dbus_wdata_o <= w_wdata;
                    end
                end
                MemBusy: begin
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        if (w_is_load) r_ldata <= w_ldata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs to mem_wb and the stall controller.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o    = NOPRegAddr;
            wreg_o  = WriteDisable;
            wdata_o = ZeroWord;
            hi_o    = ZeroWord;
            lo_o    = ZeroWord;
            whilo_o = WriteDisable;
        end else begin
            stallreq_o = (r_state == MemBusy) || w_start;
            if (w_is_mem) begin
                if (!w_aligned) begin
                    wd_o    = NOPRegAddr;
                    wreg_o  = WriteDisable;
                    wdata_o = ZeroWord;
                end else if (w_is_store) begin
                    wreg_o = WriteDisable;
                end else if (r_state == MemDone) begin
                    wdata_o = r_ldata;
                end
            end
        end
    end

endmodule
